// File: rtl/read_capture_skid_if.sv
// Bundles the DFI read-return and readback-FIFO write signals around the capture stage.
// The capture stage connects through "master". The PHY/FIFO environment connects through "slave".
interface read_capture_skid_if #(
    parameter int W = 256
) ();
    logic [W-1:0] dfi_rddata;
    logic         dfi_rddata_valid;
    logic         dfi_rddata_valid_even;
    logic         dfi_rddata_valid_odd;
    logic         dfi_clk_disable;
    logic         rdback_fifo_almost_full;
    logic         rdback_fifo_full;
    logic         rdback_fifo_wren;
    logic [W-1:0] rdback_fifo_wrdata;

    modport master (
        input  dfi_rddata, dfi_rddata_valid, dfi_rddata_valid_even, dfi_rddata_valid_odd,
        input  rdback_fifo_almost_full, rdback_fifo_full,
        output dfi_clk_disable, rdback_fifo_wren, rdback_fifo_wrdata
    );

    modport slave (
        output dfi_rddata, dfi_rddata_valid, dfi_rddata_valid_even, dfi_rddata_valid_odd,
        output rdback_fifo_almost_full, rdback_fifo_full,
        input  dfi_clk_disable, rdback_fifo_wren, rdback_fifo_wrdata
    );
endinterface

// File: rtl/read_capture_skid.sv
// DFI read-data capture stage. It realigns straddled phase returns into full words.
// It buffers the words in a first-word-fall-through skid FIFO ahead of the readback FIFO.
module read_capture_skid #(
    parameter int DQ_WIDTH    = 64,
    parameter int nCK_PER_CLK = 2,
    parameter int SKID_DEPTH  = 8,
    parameter int SKID_MARGIN = 3,
    localparam int W  = 2 * nCK_PER_CLK * DQ_WIDTH,
    localparam int LW = $clog2(SKID_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    read_capture_skid_if.master    bus,
    input  logic                   clr_stats,
    output logic                   skid_overflow,
    output logic [LW-1:0]          skid_level,
    output logic [31:0]            rd_word_cnt
);
    localparam int H  = W / 2;
    localparam int AW = $clog2(SKID_DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL    = LW'(SKID_DEPTH);
    localparam logic [LW-1:0] DISABLE_LEVEL = LW'(SKID_DEPTH - SKID_MARGIN);

    // Only the upper half of the previous word is ever needed for realignment.
    logic [W-1:0] d1;
    logic [H-1:0] d2_hi;
    logic         v1, e1, o1;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1    <= '0;
            d2_hi <= '0;
            v1    <= 1'b0;
            e1    <= 1'b0;
            o1    <= 1'b0;
        end else begin
            d1    <= bus.dfi_rddata;
            d2_hi <= d1[W-1:H];
            v1    <= bus.dfi_rddata_valid;
            e1    <= bus.dfi_rddata_valid_even;
            o1    <= bus.dfi_rddata_valid_odd;
        end
    end

    logic         push;
    logic [W-1:0] pdata;

    assign push  = v1 & ~o1;
    assign pdata = e1 ? {d1[H-1:0], d2_hi} : d1;

    // Handshake: a word moves to the readback FIFO in every cycle where rdback_fifo_wren is high.
    // wren is high whenever the skid holds data and the live rdback_fifo_full is low.
    // The word presented on wrdata in that cycle is consumed. There is no retry.
    logic [W-1:0]  mem [SKID_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_next;
    logic          pop, skid_full, wr_en, drop;

    assign pop        = (level != '0) & ~bus.rdback_fifo_full;
    assign skid_full  = (level == FULL_LEVEL);
    assign wr_en      = push & (~skid_full | pop);
    assign drop       = push & skid_full & ~pop;
    assign level_next = level + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, pop};

    assign bus.rdback_fifo_wren   = pop;
    assign bus.rdback_fifo_wrdata = (level != '0) ? mem[rd_ptr] : '0;
    assign skid_level             = level;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= pdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            level               <= '0;
            bus.dfi_clk_disable <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level               <= level_next;
            bus.dfi_clk_disable <= bus.rdback_fifo_almost_full | bus.rdback_fifo_full |
                                   (level_next >= DISABLE_LEVEL);
        end
    end

    // A clear in the same cycle as a write or a drop takes priority over that event.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rd_word_cnt   <= '0;
            skid_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_word_cnt <= rd_word_cnt + 32'd1;
            end
            if (drop) begin
                skid_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_read_capture_skid.sv
// Bench for read_capture_skid with DQ_WIDTH=8, nCK_PER_CLK=2, SKID_DEPTH=8, SKID_MARGIN=3.
// A queue model is compared on every negedge. Directed scenarios pin specific values.
module tb_read_capture_skid;
  localparam int DQW    = 8;
  localparam int NCK    = 2;
  localparam int W      = 2 * NCK * DQW;
  localparam int H      = W / 2;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 3;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_stats;
  logic          skid_overflow;
  logic [LW-1:0] skid_level;
  logic [31:0]   rd_word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  read_capture_skid_if #(.W(W)) bus ();

  read_capture_skid #(
    .DQ_WIDTH   (DQW),
    .nCK_PER_CLK(NCK),
    .SKID_DEPTH (DEPTH),
    .SKID_MARGIN(MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .clr_stats    (clr_stats),
    .skid_overflow(skid_overflow),
    .skid_level   (skid_level),
    .rd_word_cnt  (rd_word_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  logic         m_v, m_e, m_o;
  logic [W-1:0] m_d1, m_d2;
  logic [31:0]  m_cnt;
  logic         m_ovf, m_dis;
  logic         armed = 1'b0;

  always @(posedge clk) begin : ref_model
    logic         pop_m, push_m, drop_m;
    logic [W-1:0] pdata_m;
    if (rst) begin
      exp_q.delete();
      m_v = 0; m_e = 0; m_o = 0; m_d1 = '0; m_d2 = '0;
      m_cnt = '0; m_ovf = 0; m_dis = 0;
      armed = 1'b1;
    end else begin
      pop_m   = (exp_q.size() != 0) && !bus.rdback_fifo_full;
      push_m  = m_v && !m_o;
      pdata_m = m_e ? {m_d1[H-1:0], m_d2[W-1:H]} : m_d1;
      drop_m  = 1'b0;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pdata_m);
        else drop_m = 1'b1;
      end
      if (clr_stats) begin
        m_cnt = '0;
        m_ovf = 1'b0;
      end else begin
        if (pop_m) m_cnt = m_cnt + 32'd1;
        if (drop_m) m_ovf = 1'b1;
      end
      m_dis = bus.rdback_fifo_almost_full || bus.rdback_fifo_full ||
              (exp_q.size() >= DEPTH - MARGIN);
      m_d2 = m_d1;
      m_d1 = bus.dfi_rddata;
      m_v  = bus.dfi_rddata_valid;
      m_e  = bus.dfi_rddata_valid_even;
      m_o  = bus.dfi_rddata_valid_odd;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("wren", 32'(bus.rdback_fifo_wren), 32'((exp_q.size() != 0) && !bus.rdback_fifo_full));
      chk("wrdata", bus.rdback_fifo_wrdata, (exp_q.size() != 0) ? exp_q[0] : '0);
      chk("level", 32'(skid_level), exp_q.size());
      chk("overflow", 32'(skid_overflow), 32'(m_ovf));
      chk("word_cnt", rd_word_cnt, m_cnt);
      chk("clk_disable", 32'(bus.dfi_clk_disable), 32'(m_dis));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic o, input logic [W-1:0] d);
    bus.dfi_rddata_valid      = v;
    bus.dfi_rddata_valid_even = e;
    bus.dfi_rddata_valid_odd  = o;
    bus.dfi_rddata            = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clr_stats = 1'b0;
    bus.rdback_fifo_full = 1'b0;
    bus.rdback_fifo_almost_full = 1'b0;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_wren", 32'(bus.rdback_fifo_wren), 32'd0);
    chk("reset_level", 32'(skid_level), 32'd0);
    chk("reset_cnt", rd_word_cnt, 32'd0);

    // Single aligned word: written two cycles after it arrives.
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'hA1B2C3D4);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("single_wren", 32'(bus.rdback_fifo_wren), 32'd1);
    chk("single_data", bus.rdback_fifo_wrdata, 32'hA1B2C3D4);
    tick();
    @(negedge clk);
    chk("single_cnt", rd_word_cnt, 32'd1);

    // Straddled word: odd half then even half combine into one write.
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h11223344);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h55667788);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("straddle_wren", 32'(bus.rdback_fifo_wren), 32'd1);
    chk("straddle_data", bus.rdback_fifo_wrdata, 32'h77881122);
    tick();
    @(negedge clk);
    chk("straddle_once", 32'(bus.rdback_fifo_wren), 32'd0);
    chk("straddle_cnt", rd_word_cnt, 32'd2);

    // Backpressure with five buffered words, then release.
    tick();
    bus.rdback_fifo_full = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_disable", 32'(bus.dfi_clk_disable), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'hC0DE0000 + 32'(i));
    end
    tick();
    idle();
    repeat (2) tick();
    @(negedge clk);
    chk("bp_level5", 32'(skid_level), 32'd5);
    chk("bp_disable_hold", 32'(bus.dfi_clk_disable), 32'd1);
    tick();
    bus.rdback_fifo_full = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("bp_drained", 32'(skid_level), 32'd0);
    chk("bp_cnt", rd_word_cnt, 32'd7);

    // Overflow: ten words into an eight-entry skid.
    tick();
    bus.rdback_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'hF00D0000 + 32'(i));
    end
    tick();
    idle();
    repeat (2) tick();
    @(negedge clk);
    chk("ovf_level8", 32'(skid_level), 32'd8);
    chk("ovf_flag", 32'(skid_overflow), 32'd1);
    chk("ovf_head", bus.rdback_fifo_wrdata, 32'hF00D0000);
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_ovf", 32'(skid_overflow), 32'd0);
    chk("clr_cnt", rd_word_cnt, 32'd0);

    // Full skid: release downstream in the same cycle a new word is pushed.
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'hBEEF0008);
    tick();
    idle();
    bus.rdback_fifo_full = 1'b0;
    tick();
    @(negedge clk);
    chk("pp_level8", 32'(skid_level), 32'd8);
    chk("pp_wren", 32'(bus.rdback_fifo_wren), 32'd1);
    chk("pp_no_ovf", 32'(skid_overflow), 32'd0);
    chk("pp_head", bus.rdback_fifo_wrdata, 32'hF00D0001);
    repeat (12) tick();
    @(negedge clk);
    chk("pp_drained", 32'(skid_level), 32'd0);
    chk("pp_cnt", rd_word_cnt, 32'd9);

    // Reset with four buffered words and two more in flight.
    tick();
    bus.rdback_fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'hAB000000 + 32'(i));
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("rst_pre_level4", 32'(skid_level), 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'hAB000010);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'hAB000011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus.rdback_fifo_full = 1'b0;
    @(negedge clk);
    chk("rst_level", 32'(skid_level), 32'd0);
    chk("rst_cnt", rd_word_cnt, 32'd0);
    chk("rst_disable", 32'(bus.dfi_clk_disable), 32'd0);
    chk("rst_wrdata", bus.rdback_fifo_wrdata, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("rst_no_wren", 32'(bus.rdback_fifo_wren), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      tick();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 5) == 0), $urandom());
      bus.rdback_fifo_full        = ($urandom_range(0, 2) == 0);
      bus.rdback_fifo_almost_full = ($urandom_range(0, 3) == 0);
      clr_stats                   = ($urandom_range(0, 49) == 0);
    end
    tick();
    idle();
    clr_stats = 1'b0;
    bus.rdback_fifo_full = 1'b0;
    bus.rdback_fifo_almost_full = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("final_drained", 32'(skid_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
